// File: rtl/serv_ibus_pkg.sv
// Shared types and constants for the SERV instruction-bus responder.
package serv_ibus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_ACK,
    S_PF_READ,
    S_PF_WAIT
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          WAIT_MAX  = 15;
  localparam int          CNT_W     = 4;

  // Counter preload for a given WAIT; WAIT=0 never enters a wait state.
  function automatic logic [CNT_W-1:0] wait_load(input int w);
    int v;
    v = (w > 0) ? ((w > WAIT_MAX) ? WAIT_MAX - 1 : w - 1) : 0;
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/serv_ibus_resp_if.sv
// Core instruction bus plus synchronous-read memory port of the responder.
interface serv_ibus_resp_if #(
  parameter int AW = 10
);
  logic [31:0]   i_ibus_adr;
  logic          i_ibus_cyc;
  logic [31:0]   o_ibus_rdt;
  logic          o_ibus_ack;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_en;
  logic [31:0]   i_mem_rdata;

  modport slave (
    input  i_ibus_adr, i_ibus_cyc, i_mem_rdata,
    output o_ibus_rdt, o_ibus_ack, o_mem_addr, o_mem_en
  );

  modport master (
    output i_ibus_adr, i_ibus_cyc, i_mem_rdata,
    input  o_ibus_rdt, o_ibus_ack, o_mem_addr, o_mem_en
  );
endinterface

// File: rtl/serv_ibus_pfbuf.sv
// One-word sequential prefetch buffer with address compare for demand lookups.
module serv_ibus_pfbuf #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          fill,
  input  logic [31:0]   fill_data,
  input  logic          commit,
  input  logic          inval,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [31:0]   pf_data
);

  logic [AW-1:0] pf_addr;
  logic          pf_valid;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      pf_addr  <= '0;
      pf_data  <= '0;
      pf_valid <= 1'b0;
    end else begin
      // A new prefetch invalidates the old word until its data is committed.
      if (start) begin
        pf_addr  <= start_addr;
        pf_valid <= 1'b0;
      end
      if (fill)   pf_data  <= fill_data;
      if (commit) pf_valid <= 1'b1;
      if (inval)  pf_valid <= 1'b0;
    end
  end

  assign hit = pf_valid && (lookup_addr == pf_addr);

endmodule

// File: rtl/serv_ibus_resp.sv
// Instruction-bus responder: IDLE->READ->(WAIT)->ACK over a sync-read memory.
// Optional sequential prefetch buffer under SERV_IBUS_PREFETCH_EN.
module serv_ibus_resp
  import serv_ibus_pkg::*;
#(
  parameter int          AW          = 10,
  parameter int          WAIT        = 0,
  parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
  input  logic             clk,
  input  logic             i_rst,
  serv_ibus_resp_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT);
  localparam bit               HAS_WAIT  = (WAIT != 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      rdt;
  logic             rdt_ld_mem;
  logic             mem_en;
  logic             ack;
  logic [AW-1:0]    req_addr;
  logic [AW-1:0]    mem_addr;
  logic             unused_adr;

  assign req_addr   = bus.i_ibus_adr[AW+1:2];
  assign unused_adr = ^{bus.i_ibus_adr[31:AW+2], bus.i_ibus_adr[1:0]};

`ifdef SERV_IBUS_PREFETCH_EN
  logic          pf_hit, pf_start, pf_fill, pf_commit, pf_inval, rdt_ld_pf;
  logic          pf_pend, pf_pend_nxt;
  logic [AW-1:0] last_addr, last_nxt, seq_addr;
  logic [31:0]   pf_data;

  assign seq_addr = last_addr + AW'(1);

  serv_ibus_pfbuf #(.AW(AW)) u_pfbuf (
    .clk         (clk),
    .i_rst       (i_rst),
    .start       (pf_start),
    .start_addr  (seq_addr),
    .fill        (pf_fill),
    .fill_data   (bus.i_mem_rdata),
    .commit      (pf_commit),
    .inval       (pf_inval),
    .lookup_addr (req_addr),
    .hit         (pf_hit),
    .pf_data     (pf_data)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      pf_pend   <= 1'b0;
      last_addr <= '0;
    end else begin
      pf_pend   <= pf_pend_nxt;
      last_addr <= last_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rdt_ld_mem = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = req_addr;
    ack        = 1'b0;
`ifdef SERV_IBUS_PREFETCH_EN
    pf_start    = 1'b0;
    pf_fill     = 1'b0;
    pf_commit   = 1'b0;
    pf_inval    = 1'b0;
    rdt_ld_pf   = 1'b0;
    pf_pend_nxt = pf_pend;
    last_nxt    = last_addr;
`endif
    case (state)
      S_IDLE: begin
        if (bus.i_ibus_cyc) begin
`ifdef SERV_IBUS_PREFETCH_EN
          last_nxt    = req_addr;
          pf_pend_nxt = 1'b0;
          if (pf_hit) begin
            rdt_ld_pf = 1'b1;
            state_nxt = S_ACK;
          end else begin
            pf_inval  = 1'b1;
            mem_en    = 1'b1;
            state_nxt = S_READ;
          end
`else
          mem_en    = 1'b1;
          state_nxt = S_READ;
`endif
        end
`ifdef SERV_IBUS_PREFETCH_EN
        else if (pf_pend) begin
          pf_pend_nxt = 1'b0;
          pf_start    = 1'b1;
          mem_en      = 1'b1;
          mem_addr    = seq_addr;
          state_nxt   = S_PF_READ;
        end
`endif
      end
      S_READ: begin
        // Capture even on abort so rdt keeps the last word read.
        rdt_ld_mem = 1'b1;
        if (!bus.i_ibus_cyc) begin
          state_nxt = S_IDLE;
        end else if (HAS_WAIT) begin
          cnt_nxt   = WAIT_LOAD;
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_ACK;
        end
      end
      S_WAIT: begin
        if (!bus.i_ibus_cyc)  state_nxt = S_IDLE;
        else if (cnt == '0)   state_nxt = S_ACK;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      S_ACK: begin
        ack       = 1'b1;
        state_nxt = S_IDLE;
`ifdef SERV_IBUS_PREFETCH_EN
        pf_pend_nxt = 1'b1;
`endif
      end
`ifdef SERV_IBUS_PREFETCH_EN
      S_PF_READ, S_PF_WAIT: begin
        // Demand wins: drop the prefetch and start the demand read now.
        if (bus.i_ibus_cyc) begin
          last_nxt  = req_addr;
          mem_en    = 1'b1;
          state_nxt = S_READ;
        end else if (state == S_PF_READ) begin
          pf_fill = 1'b1;
          if (HAS_WAIT) begin
            cnt_nxt   = WAIT_LOAD;
            state_nxt = S_PF_WAIT;
          end else begin
            pf_commit = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (cnt == '0) begin
          pf_commit = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      rdt   <= RESET_INSTR;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (rdt_ld_mem) rdt <= bus.i_mem_rdata;
`ifdef SERV_IBUS_PREFETCH_EN
      else if (rdt_ld_pf) rdt <= pf_data;
`endif
    end
  end

  assign bus.o_ibus_rdt = rdt;
  assign bus.o_ibus_ack = ack & ~i_rst;
  assign bus.o_mem_en   = mem_en & ~i_rst;
  assign bus.o_mem_addr = mem_addr;

endmodule

// File: tb/tb_serv_ibus_resp.sv
// Scoreboard bench: WAIT=0 and WAIT=3 responders side by side, prefetch cases when enabled.
`timescale 1ns/1ps
module tb_serv_ibus_resp;
  import serv_ibus_pkg::*;

  localparam int AW = 10;

  typedef struct {
    int          due;
    logic [31:0] rdt;
  } exp_t;

  logic clk   = 1'b0;
  logic i_rst = 1'b1;
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  logic prev_ack_a = 1'b0;
  logic prev_ack_b = 1'b0;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  serv_ibus_resp_if #(.AW(AW)) bus_a ();
  serv_ibus_resp_if #(.AW(AW)) bus_b ();

  serv_ibus_resp #(.AW(AW), .WAIT(0), .RESET_INSTR(32'h00000013)) dut_a (
    .clk(clk), .i_rst(i_rst), .bus(bus_a)
  );
  serv_ibus_resp #(.AW(AW), .WAIT(3), .RESET_INSTR(32'h00000013)) dut_b (
    .clk(clk), .i_rst(i_rst), .bus(bus_b)
  );

  // Synchronous-read memory models.
  always @(posedge clk) begin
    if (i_rst) begin
      bus_a.i_mem_rdata <= '0;
      bus_b.i_mem_rdata <= '0;
    end else begin
      if (bus_a.o_mem_en) bus_a.i_mem_rdata <= mem_a[bus_a.o_mem_addr];
      if (bus_b.o_mem_en) bus_b.i_mem_rdata <= mem_b[bus_b.o_mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (bus_a.o_ibus_ack === 1'b1) begin
      check("a_ack_spacing", 32'(prev_ack_a), 32'h0);
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_ack: got ack=1 expected ack=0 (cycle %0d)", cyc_cnt);
      end else begin
        e = q_a.pop_front();
        check("a_ack_cycle", 32'(cyc_cnt), 32'(e.due));
        check("a_ack_rdt", bus_a.o_ibus_rdt, e.rdt);
      end
    end
    prev_ack_a = bus_a.o_ibus_ack;
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (bus_b.o_ibus_ack === 1'b1) begin
      check("b_ack_spacing", 32'(prev_ack_b), 32'h0);
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_ack: got ack=1 expected ack=0 (cycle %0d)", cyc_cnt);
      end else begin
        e = q_b.pop_front();
        check("b_ack_cycle", 32'(cyc_cnt), 32'(e.due));
        check("b_ack_rdt", bus_b.o_ibus_rdt, e.rdt);
      end
    end
    prev_ack_b = bus_b.o_ibus_ack;
  end

  task automatic drive(input bit b, input logic cyc, input logic [31:0] adr);
    if (b) begin
      bus_b.i_ibus_cyc = cyc;
      bus_b.i_ibus_adr = adr;
    end else begin
      bus_a.i_ibus_cyc = cyc;
      bus_a.i_ibus_adr = adr;
    end
  endtask

  function automatic logic get_ack(input bit b);
    return b ? bus_b.o_ibus_ack : bus_a.o_ibus_ack;
  endfunction

  // Called just after a rising edge; holds cyc until ack, then drops it for one
  // idle cycle unless hold is set (back-to-back request).
  task automatic fetch(input bit b, input logic [31:0] adr, input logic [31:0] exp_rdt,
                       input int lat, input logic [AW-1:0] exp_maddr, input bit hold);
    exp_t e;
    bit   got;
    drive(b, 1'b1, adr);
    e.due = cyc_cnt + lat;
    e.rdt = exp_rdt;
    if (b) q_b.push_back(e); else q_a.push_back(e);
    @(negedge clk);
    if (lat > 1) begin
      check(b ? "b_mem_en" : "a_mem_en", 32'(b ? bus_b.o_mem_en : bus_a.o_mem_en), 32'h1);
      check(b ? "b_mem_addr" : "a_mem_addr",
            32'(b ? bus_b.o_mem_addr : bus_a.o_mem_addr), 32'(exp_maddr));
    end else begin
      check("a_hit_no_mem_en", 32'(bus_a.o_mem_en), 32'h0);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (get_ack(b) === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack expected ack for adr %h", adr);
    end
    @(posedge clk); #1;
    if (!hold) begin
      drive(b, 1'b0, adr);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'hDEAD0000 | 32'(i);
      mem_b[i] = 32'hBEEF0000 | 32'(i);
    end
    mem_a[0]    = 32'h00000513;
    mem_a[1]    = 32'h00108093;
    mem_a[3]    = 32'h00310193;
    mem_a[4]    = 32'h00A00093;
    mem_a[16]   = 32'h04000293;
    mem_a[1023] = 32'h3FF00313;
    mem_b[2]    = 32'h00200113;
    mem_b[4]    = 32'h00A00093;

    drive(1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    i_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;

    // Out of reset, no request.
    @(negedge clk);
    check("a_rst_rdt", bus_a.o_ibus_rdt, 32'h00000013);
    check("a_rst_ack", 32'(bus_a.o_ibus_ack), 32'h0);
    check("a_rst_mem_en", 32'(bus_a.o_mem_en), 32'h0);
    check("b_rst_rdt", bus_b.o_ibus_rdt, 32'h00000013);
    check("b_rst_ack", 32'(bus_b.o_ibus_ack), 32'h0);
    check("b_rst_mem_en", 32'(bus_b.o_mem_en), 32'h0);
    @(posedge clk); #1;

    // WAIT=0: basic read, alias, high bits ignored, back-to-back.
    fetch(1'b0, 32'h00000010, 32'h00A00093, 2, 10'd4, 1'b0);
    fetch(1'b0, 32'h00001004, 32'h00108093, 2, 10'd1, 1'b0);
    fetch(1'b0, 32'hFFFFF00C, 32'h00310193, 2, 10'd3, 1'b1);
    fetch(1'b0, 32'h00000010, 32'h00A00093, 2, 10'd4, 1'b0);

    // WAIT=3: read acks at cycle 5.
    fetch(1'b1, 32'h00000010, 32'h00A00093, 5, 10'd4, 1'b0);

    // WAIT=3 abort: cyc dropped in cycle 3, no ack, captured word held.
    drive(1'b1, 1'b1, 32'h00000008);
    repeat (3) begin @(posedge clk); #1; end
    drive(1'b1, 1'b0, 32'h00000008);
    repeat (6) @(negedge clk);
    check("b_abort_rdt_held", bus_b.o_ibus_rdt, 32'h00200113);
    @(posedge clk); #1;
    fetch(1'b1, 32'h00000010, 32'h00A00093, 5, 10'd4, 1'b0);

    // Reset in READ with cyc held, then reset over an IDLE request.
    drive(1'b0, 1'b1, 32'h00000010);
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("a_rst_idle_mem_en", 32'(bus_a.o_mem_en), 32'h0);
    check("a_rst_idle_ack", 32'(bus_a.o_ibus_ack), 32'h0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    repeat (5) @(negedge clk);
    check("a_rst_mid_rdt", bus_a.o_ibus_rdt, 32'h00000013);
    @(posedge clk); #1;

`ifdef SERV_IBUS_PREFETCH_EN
    // Sequential prefetch hit, then a miss that clears the buffer.
    fetch(1'b0, 32'h00000000, 32'h00000513, 2, 10'd0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    fetch(1'b0, 32'h00000004, 32'h00108093, 1, 10'd1, 1'b0);
    fetch(1'b0, 32'h00000040, 32'h04000293, 2, 10'd16, 1'b0);
    check("a_pf_valid_cleared", 32'(dut_a.u_pfbuf.pf_valid), 32'h0);
    // Prefetch after the last word wraps to word 0.
    fetch(1'b0, 32'h00000FFC, 32'h3FF00313, 2, 10'd1023, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    fetch(1'b0, 32'h00000000, 32'h00000513, 1, 10'd0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'h0);
    check("b_queue_drained", 32'(q_b.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serv_ibus_resp.md
SERV_IBUS_RESP -- requirements
Module: serv_ibus_resp

Interface
REQ-001 Parameter AW, default 10: word-address width of the instruction memory (2^AW 32-bit words).
REQ-002 Parameter WAIT, default 0: extra wait cycles inserted after memory read data is valid (0..15).
REQ-003 Parameter RESET_INSTR, default 32'h00000013 (addi x0,x0,0): value of o_ibus_rdt out of reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_ibus_adr  input  32  byte address from the core's instruction bus; bits [1:0] are ignored.
REQ-007 i_ibus_cyc  input  1  request valid; the core holds it high until ack.
REQ-008 o_ibus_rdt  output  32  instruction word, registered; bits [31:2] feed the decoder.
REQ-009 o_ibus_ack  output  1  one-cycle pulse; o_ibus_rdt is valid in the same cycle.
REQ-010 o_mem_addr  output  AW  word address to the synchronous-read memory.
REQ-011 o_mem_en  output  1  memory read strobe.
REQ-012 i_mem_rdata  input  32  memory read data, valid the cycle after o_mem_en.

Function
REQ-013 The FSM SHALL have states IDLE, READ, WAIT and ACK.
REQ-014 In IDLE with i_ibus_cyc=1: o_mem_en=1 and o_mem_addr=i_ibus_adr[AW+1:2], both combinational; next state READ.
REQ-015 In READ: capture i_mem_rdata into o_ibus_rdt; go to ACK if WAIT=0, else load the wait counter with WAIT-1 and go to WAIT.
REQ-016 In WAIT: decrement the counter; at 0, go to ACK. o_ibus_rdt is held throughout.
REQ-017 In ACK: o_ibus_ack=1 for exactly this cycle; next state IDLE.
REQ-018 Latency from the cycle i_ibus_cyc is first seen in IDLE to ack SHALL be 2+WAIT cycles.
REQ-019 Address bits above AW+1 are ignored, so addresses alias modulo 2^AW words.
REQ-020 If i_ibus_cyc drops in READ or WAIT (abort): return to IDLE with no ack; o_ibus_rdt keeps the captured value.
REQ-021 If i_ibus_cyc is still high in the cycle after ACK, it is treated as a new request.
REQ-022 o_ibus_ack SHALL never be asserted in two consecutive cycles.

Reset
REQ-023 On i_rst: state=IDLE, o_ibus_ack=0, o_ibus_rdt=RESET_INSTR, wait counter=0, prefetch buffer invalid; o_mem_en=0 during the reset cycle.
REQ-024 Reset asserted mid-transaction aborts it with no ack in any following cycle.

Configuration
REQ-025 Macro SERV_IBUS_PREFETCH_EN SHALL enable a one-word sequential prefetch buffer (pf_addr, pf_data, pf_valid).
REQ-026 With the macro, after ACK, if IDLE sees i_ibus_cyc=0, the block SHALL issue a read of (last word address + 1) mod 2^AW, honour WAIT, then set pf_valid.
REQ-027 With the macro, a request in IDLE whose word address equals pf_addr while pf_valid=1 SHALL go directly to ACK; o_ibus_rdt=pf_data; latency is 1 cycle.
REQ-028 With the macro, a mismatched request SHALL clear pf_valid and take the normal read path.
REQ-029 With the macro, a demand request arriving while a prefetch is in flight SHALL abort the prefetch (no pf_valid) and issue the demand read in that same cycle; demand always has priority.
REQ-030 Without the macro: no prefetch logic and no extra o_mem_en strobes; behaviour is exactly REQ-013..024.

Structure
REQ-031 Package serv_ibus_pkg SHALL hold the FSM state enum, the NOP constant 32'h00000013 and the maximum WAIT value.
REQ-032 Sub-module serv_ibus_pfbuf SHALL implement the prefetch buffer and its address compare; it is instantiated only under SERV_IBUS_PREFETCH_EN.

Verification
REQ-033 Reset release, no request -> o_ibus_rdt=32'h00000013, o_ibus_ack=0, o_mem_en=0.
REQ-034 WAIT=0; mem[4]=32'h00A00093; cyc=1, adr=32'h10 at cycle 0 -> o_mem_addr=4 at cycle 0; ack with rdt=32'h00A00093 at cycle 2 only.
REQ-035 WAIT=3, same read -> ack at cycle 5; cyc dropped at cycle 3 instead -> no ack, FSM returns to IDLE.
REQ-036 AW=10; adr=32'h00001004 -> o_mem_addr=1 (alias).
REQ-037 Prefetch build, WAIT=0: fetch adr=32'h0, idle 3 cycles, fetch adr=32'h4 -> ack 1 cycle after cyc with mem[1]; then fetch adr=32'h40 -> 2-cycle ack, pf_valid cleared.
REQ-038 Prefetch build, AW=10: fetch word 1023, then word 0 -> prefetch wraps to address 0 and the word-0 request hits.
